// File: rtl/seq_upc_loop_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : seq_upc_loop_monitor
//  Description : Activity monitor for an HLS accelerator. It tracks the
//                ap_ctrl_hs handshake, one sequential loop and one pipelined
//                loop. Counters saturate and freeze on finish.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_upc_loop_monitor #(
    parameter int STATE_W = 27,
    parameter int UPC_W   = 1,
    parameter int CNT_W   = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               finish,
    input  logic               mod_ap_start,
    input  logic               mod_ap_ready,
    input  logic               mod_ap_done,
    input  logic               mod_ap_continue,
    input  logic [STATE_W-1:0] seq_cur_state,
    input  logic [STATE_W-1:0] seq_pre_state0,
    input  logic [STATE_W-1:0] seq_pre_state1,
    input  logic [1:0]         seq_pre_valid,
    input  logic [STATE_W-1:0] seq_iter_start_state,
    input  logic [STATE_W-1:0] seq_iter_end_state,
    input  logic [STATE_W-1:0] seq_post_state,
    input  logic               seq_end_valid,
    input  logic               seq_post_valid,
    input  logic               seq_one_state_loop,
    input  logic [UPC_W-1:0]   upc_cur_state,
    input  logic [UPC_W-1:0]   upc_iter_start_state,
    input  logic [UPC_W-1:0]   upc_iter_end_state,
    input  logic               upc_iter_start_enable,
    input  logic               upc_iter_start_block,
    input  logic               upc_iter_end_enable,
    input  logic               upc_iter_end_block,
    input  logic               upc_loop_start,
    input  logic               upc_loop_ready,
    input  logic               upc_loop_done,
    input  logic               upc_loop_continue,
    output logic               mod_busy,
    output logic               seq_in_loop,
    output logic               upc_active,
    output logic               frozen,
    output logic [CNT_W-1:0]   mod_start_cnt,
    output logic [CNT_W-1:0]   mod_done_cnt,
    output logic [CNT_W-1:0]   mod_busy_cycles,
    output logic [CNT_W-1:0]   seq_entry_cnt,
    output logic [CNT_W-1:0]   seq_iter_cnt,
    output logic [CNT_W-1:0]   seq_loop_cycles,
    output logic [CNT_W-1:0]   upc_invoke_cnt,
    output logic [CNT_W-1:0]   upc_iter_start_cnt,
    output logic [CNT_W-1:0]   upc_iter_end_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_IN_LOOP = 2'd2
    } seq_state_e;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        sat_inc = (en && (v != CNT_MAX)) ? (v + CNT_ONE) : v;
    endfunction

    seq_state_e         state_q, state_d;
    logic [STATE_W-1:0] prev_q;
    logic               frozen_q;
    logic               busy_q, busy_d;
    logic               active_q, active_d;
    logic [CNT_W-1:0]   start_cnt_q, start_cnt_d;
    logic [CNT_W-1:0]   done_cnt_q, done_cnt_d;
    logic [CNT_W-1:0]   busy_cyc_q, busy_cyc_d;
    logic [CNT_W-1:0]   entry_q, entry_d;
    logic [CNT_W-1:0]   iter_q, iter_d;
    logic [CNT_W-1:0]   loop_cyc_q, loop_cyc_d;
    logic [CNT_W-1:0]   invoke_q, invoke_d;
    logic [CNT_W-1:0]   upc_s_q, upc_s_d;
    logic [CNT_W-1:0]   upc_e_q, upc_e_d;

    // A cycle with finish=1 is discarded, as is every cycle after freezing.
    logic w_upd;
    assign w_upd = ~frozen_q & ~finish;

    logic w_pre_hit, w_start_hit, w_post_hit, w_end_hit, w_start_fire, w_end_fire;
    assign w_pre_hit   = ((seq_cur_state == seq_pre_state0) & seq_pre_valid[0]) |
                         ((seq_cur_state == seq_pre_state1) & seq_pre_valid[1]);
    assign w_start_hit = (seq_cur_state == seq_iter_start_state);
    assign w_post_hit  = (seq_cur_state == seq_post_state) & seq_post_valid;
    // Repeated end state only counts again for single-state loop bodies.
    assign w_end_hit   = (seq_cur_state == seq_iter_end_state) & seq_end_valid &
                         ((prev_q != seq_iter_end_state) | seq_one_state_loop);
    assign w_start_fire = (upc_cur_state == upc_iter_start_state) &
                          upc_iter_start_enable & ~upc_iter_start_block;
    assign w_end_fire   = (upc_cur_state == upc_iter_end_state) &
                          upc_iter_end_enable & ~upc_iter_end_block;

    // Next-state logic for the loop FSM, flags and all counters.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        active_d    = active_q;
        start_cnt_d = sat_inc(start_cnt_q, mod_ap_start & mod_ap_ready);
        done_cnt_d  = sat_inc(done_cnt_q, mod_ap_done & mod_ap_continue);
        busy_cyc_d  = sat_inc(busy_cyc_q, busy_q);
        entry_d     = entry_q;
        iter_d      = iter_q;
        loop_cyc_d  = sat_inc(loop_cyc_q, state_q == S_IN_LOOP);
        invoke_d    = sat_inc(invoke_q, upc_loop_start & upc_loop_ready);
        upc_s_d     = sat_inc(upc_s_q, w_start_fire);
        upc_e_d     = sat_inc(upc_e_q, w_end_fire);

        // Set has priority over clear for both busy-style flags.
        if (mod_ap_start && !busy_q) begin
            busy_d = 1'b1;
        end else if (mod_ap_done && mod_ap_continue) begin
            busy_d = 1'b0;
        end
        if (upc_loop_start) begin
            active_d = 1'b1;
        end else if (upc_loop_done && upc_loop_continue) begin
            active_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (w_pre_hit) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (w_start_hit) begin
                    state_d = S_IN_LOOP;
                    entry_d = sat_inc(entry_q, 1'b1);
                    // Entry cycle may already be the end of a one-state body.
                    iter_d  = sat_inc(iter_q, w_end_hit);
                end
            end
            S_IN_LOOP: begin
                iter_d = sat_inc(iter_q, w_end_hit);
                if (w_post_hit) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register: asynchronous clear, updates gated by freeze.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            prev_q      <= '0;
            frozen_q    <= 1'b0;
            busy_q      <= 1'b0;
            active_q    <= 1'b0;
            start_cnt_q <= '0;
            done_cnt_q  <= '0;
            busy_cyc_q  <= '0;
            entry_q     <= '0;
            iter_q      <= '0;
            loop_cyc_q  <= '0;
            invoke_q    <= '0;
            upc_s_q     <= '0;
            upc_e_q     <= '0;
        end else begin
            frozen_q <= frozen_q | finish;
            if (w_upd) begin
                state_q     <= state_d;
                prev_q      <= seq_cur_state;
                busy_q      <= busy_d;
                active_q    <= active_d;
                start_cnt_q <= start_cnt_d;
                done_cnt_q  <= done_cnt_d;
                busy_cyc_q  <= busy_cyc_d;
                entry_q     <= entry_d;
                iter_q      <= iter_d;
                loop_cyc_q  <= loop_cyc_d;
                invoke_q    <= invoke_d;
                upc_s_q     <= upc_s_d;
                upc_e_q     <= upc_e_d;
            end
        end
    end

    assign mod_busy           = busy_q;
    assign seq_in_loop        = (state_q == S_IN_LOOP);
    assign upc_active         = active_q;
    assign frozen             = frozen_q;
    assign mod_start_cnt      = start_cnt_q;
    assign mod_done_cnt       = done_cnt_q;
    assign mod_busy_cycles    = busy_cyc_q;
    assign seq_entry_cnt      = entry_q;
    assign seq_iter_cnt       = iter_q;
    assign seq_loop_cycles    = loop_cyc_q;
    assign upc_invoke_cnt     = invoke_q;
    assign upc_iter_start_cnt = upc_s_q;
    assign upc_iter_end_cnt   = upc_e_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_upc_loop_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_upc_loop_monitor
//  Description : Scoreboard bench for seq_upc_loop_monitor (CNT_W=32 and a
//                CNT_W=4 instance sharing the same stimulus).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_upc_loop_monitor;

    localparam int SW = 27;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, finish;
    logic          ap_start, ap_ready, ap_done, ap_cont;
    logic [SW-1:0] cur, pre0, pre1, it_s, it_e, post;
    logic [1:0]    pre_v;
    logic          end_v, post_v, one_st;
    logic [0:0]    u_cur, u_s, u_e;
    logic          u_se, u_sb, u_ee, u_eb, l_start, l_ready, l_done, l_cont;

    logic        busy, inl, act, frz;
    logic [31:0] c_st, c_dn, c_bc, c_en, c_it, c_lc, c_iv, c_us, c_ue;
    logic        s_busy, s_inl, s_act, s_frz;
    logic [3:0]  s_st, s_dn, s_bc, s_en, s_it, s_lc, s_iv, s_us, s_ue;

    seq_upc_loop_monitor #(.STATE_W(SW), .UPC_W(1), .CNT_W(32)) dut (
        .clock(clk), .reset(reset), .finish(finish),
        .mod_ap_start(ap_start), .mod_ap_ready(ap_ready), .mod_ap_done(ap_done), .mod_ap_continue(ap_cont),
        .seq_cur_state(cur), .seq_pre_state0(pre0), .seq_pre_state1(pre1), .seq_pre_valid(pre_v),
        .seq_iter_start_state(it_s), .seq_iter_end_state(it_e), .seq_post_state(post),
        .seq_end_valid(end_v), .seq_post_valid(post_v), .seq_one_state_loop(one_st),
        .upc_cur_state(u_cur), .upc_iter_start_state(u_s), .upc_iter_end_state(u_e),
        .upc_iter_start_enable(u_se), .upc_iter_start_block(u_sb),
        .upc_iter_end_enable(u_ee), .upc_iter_end_block(u_eb),
        .upc_loop_start(l_start), .upc_loop_ready(l_ready), .upc_loop_done(l_done), .upc_loop_continue(l_cont),
        .mod_busy(busy), .seq_in_loop(inl), .upc_active(act), .frozen(frz),
        .mod_start_cnt(c_st), .mod_done_cnt(c_dn), .mod_busy_cycles(c_bc),
        .seq_entry_cnt(c_en), .seq_iter_cnt(c_it), .seq_loop_cycles(c_lc),
        .upc_invoke_cnt(c_iv), .upc_iter_start_cnt(c_us), .upc_iter_end_cnt(c_ue)
    );

    seq_upc_loop_monitor #(.STATE_W(SW), .UPC_W(1), .CNT_W(4)) dut_small (
        .clock(clk), .reset(reset), .finish(finish),
        .mod_ap_start(ap_start), .mod_ap_ready(ap_ready), .mod_ap_done(ap_done), .mod_ap_continue(ap_cont),
        .seq_cur_state(cur), .seq_pre_state0(pre0), .seq_pre_state1(pre1), .seq_pre_valid(pre_v),
        .seq_iter_start_state(it_s), .seq_iter_end_state(it_e), .seq_post_state(post),
        .seq_end_valid(end_v), .seq_post_valid(post_v), .seq_one_state_loop(one_st),
        .upc_cur_state(u_cur), .upc_iter_start_state(u_s), .upc_iter_end_state(u_e),
        .upc_iter_start_enable(u_se), .upc_iter_start_block(u_sb),
        .upc_iter_end_enable(u_ee), .upc_iter_end_block(u_eb),
        .upc_loop_start(l_start), .upc_loop_ready(l_ready), .upc_loop_done(l_done), .upc_loop_continue(l_cont),
        .mod_busy(s_busy), .seq_in_loop(s_inl), .upc_active(s_act), .frozen(s_frz),
        .mod_start_cnt(s_st), .mod_done_cnt(s_dn), .mod_busy_cycles(s_bc),
        .seq_entry_cnt(s_en), .seq_iter_cnt(s_it), .seq_loop_cycles(s_lc),
        .upc_invoke_cnt(s_iv), .upc_iter_start_cnt(s_us), .upc_iter_end_cnt(s_ue)
    );

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   stim_done = 1'b0;

    function automatic logic [31:0] dut_val(input int sel);
        case (sel)
            0:  dut_val = {31'd0, busy};
            1:  dut_val = {31'd0, inl};
            2:  dut_val = {31'd0, act};
            3:  dut_val = {31'd0, frz};
            4:  dut_val = c_st;
            5:  dut_val = c_dn;
            6:  dut_val = c_bc;
            7:  dut_val = c_en;
            8:  dut_val = c_it;
            9:  dut_val = c_lc;
            10: dut_val = c_iv;
            11: dut_val = c_us;
            12: dut_val = c_ue;
            13: dut_val = {28'd0, s_st};
            14: dut_val = {31'd0, s_frz};
            default: dut_val = 32'hDEAD_BEEF;
        endcase
    endfunction

    // Stimulus side: record what the DUT must show at the next sample point.
    task automatic expect_val(input int sel, input logic [31:0] exp, input string name);
        exp_t e;
        e.sel = sel; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    task automatic expect_all_zero(input string tag);
        for (int i = 0; i <= 12; i++) expect_val(i, 32'd0, $sformatf("%s_out%0d", tag, i));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are stable at the falling edge; drain the scoreboard there.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] got;
            e   = sb.pop_front();
            got = dut_val(e.sel);
            total++;
            if (got !== e.exp) begin
                bad++;
                $display("FAIL %s: got=%0d expected=%0d", e.name, got, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: stimulus did not complete");
        $fatal(1, "timeout");
    end

    // Pipelined-loop start pattern (block on cycles 3 and 7) and its fires.
    bit blk_pat  [10] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    bit fire_pat [12] = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0, 0};

    initial begin
        reset = 1'b0; finish = 1'b0;
        ap_start = 0; ap_ready = 0; ap_done = 0; ap_cont = 0;
        pre0 = SW'(1) << 0; pre1 = SW'(1) << 1; it_s = SW'(1) << 2;
        it_e = SW'(1) << 3; post = SW'(1) << 4; cur = SW'(1) << 5;
        pre_v = 2'b01; end_v = 1; post_v = 1; one_st = 0;
        u_cur = 1'b0; u_s = 1'b0; u_e = 1'b0;
        u_se = 0; u_sb = 0; u_ee = 0; u_eb = 0;
        l_start = 0; l_ready = 0; l_done = 0; l_cont = 0;

        // Reset state
        tick(); tick();
        expect_all_zero("rst");
        expect_val(14, 0, "rst_small_frozen");
        @(negedge clk); #1;
        reset = 1'b1;

        // Module handshake: accept in cycle 1, complete in cycle 6
        tick();
        ap_start = 1; ap_ready = 1;
        tick();
        expect_val(4, 1, "hs_start_cnt");
        expect_val(0, 1, "hs_busy_set");
        ap_start = 0; ap_ready = 0;
        repeat (4) tick();
        expect_val(6, 4, "hs_busy_cyc_mid");
        ap_done = 1; ap_cont = 1;
        tick();
        expect_val(5, 1, "hs_done_cnt");
        expect_val(0, 0, "hs_busy_clr");
        expect_val(6, 5, "hs_busy_cycles");
        ap_done = 0; ap_cont = 0;

        // Sequential loop: pre0, start, (end, start) x2, end, post
        cur = pre0; tick();
        expect_val(1, 0, "seq_armed_not_in");
        cur = it_s; tick();
        expect_val(1, 1, "seq_in_loop");
        expect_val(7, 1, "seq_entry");
        for (int k = 0; k < 3; k++) begin
            cur = it_e; tick();
            if (k < 2) begin cur = it_s; tick(); end
        end
        expect_val(8, 3, "seq_iter3");
        cur = post; tick();
        expect_val(1, 0, "seq_exit");
        expect_val(9, 6, "seq_loop_cycles");
        // pre_state1 is invalid: must not arm
        cur = pre1; tick();
        cur = it_s; tick();
        expect_val(1, 0, "seq_pre1_invalid");
        expect_val(7, 1, "seq_entry_hold");

        // One-state loop with seq_one_state_loop=1, then =0
        it_e = it_s; one_st = 1;
        cur = pre0; tick();
        repeat (4) begin cur = it_s; tick(); end
        cur = post; tick();
        expect_val(8, 7, "one_state_iter4");
        expect_val(7, 2, "one_state_entry");
        expect_val(9, 10, "one_state_cycles");
        one_st = 0;
        cur = pre0; tick();
        repeat (4) begin cur = it_s; tick(); end
        cur = post; tick();
        expect_val(8, 8, "one_state_off_iter1");
        cur = SW'(1) << 5;

        // Pipelined loop: 10 start cycles, 2 blocked, end enable lags by 2
        l_start = 1; l_ready = 1;
        for (int c = 0; c < 12; c++) begin
            u_se = (c < 10);
            u_sb = (c < 10) ? blk_pat[c] : 1'b0;
            u_ee = (c >= 2) ? fire_pat[c-2] : 1'b0;
            tick();
            l_start = 0; l_ready = 0;
            if (c == 0) begin
                expect_val(10, 1, "upc_invoke");
                expect_val(2, 1, "upc_active");
            end
            if (c == 9) begin
                expect_val(11, 8, "upc_start_cnt");
                expect_val(12, 6, "upc_end_cnt_mid");
            end
        end
        u_se = 0; u_sb = 0; u_ee = 0;
        expect_val(12, 8, "upc_end_cnt_drain");
        // set wins over clear; then clear alone
        l_start = 1; l_done = 1; l_cont = 1; tick();
        expect_val(2, 1, "upc_set_wins");
        expect_val(10, 1, "upc_invoke_hold");
        l_start = 0; tick();
        expect_val(2, 0, "upc_clear");
        l_done = 0; l_cont = 0;

        // Asynchronous reset between edges
        #2;
        reset = 1'b0;
        #1;
        expect_all_zero("midrst");
        @(negedge clk); #1;
        reset = 1'b1;
        cur = it_s; tick();
        expect_val(1, 0, "midrst_fsm_idle");

        // Saturation: 20 accepts
        ap_start = 1; ap_ready = 1;
        repeat (20) tick();
        expect_val(13, 15, "sat_small_start");
        expect_val(4, 20, "sat_big_start");
        expect_val(6, 19, "sat_busy_cycles");

        // Freeze: finish cycle's own updates are dropped
        finish = 1; cur = pre0; tick();
        expect_val(3, 1, "frz_flag");
        expect_val(14, 1, "frz_small_flag");
        expect_val(4, 20, "frz_start_hold");
        finish = 0; cur = it_s;
        repeat (3) tick();
        expect_val(4, 20, "frz_start_hold2");
        expect_val(6, 19, "frz_busy_cyc_hold");
        expect_val(1, 0, "frz_fsm_hold");
        expect_val(3, 1, "frz_sticky");
        ap_start = 0; ap_ready = 0;

        @(negedge clk); #1;
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL scoreboard_drain: got=%0d expected=0", sb.size());
        end
        stim_done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
